// File: rtl/tamagotchi_pkg.sv
// Shared action codes, scheduler state and the round-robin pick helper
// used by the tamagotchi button front-end.
package tamagotchi_pkg;
  localparam int ACT_W   = 2;
  localparam int NUM_ACT = 4;

  localparam logic [ACT_W-1:0] ACT_SALUD     = 2'd0;
  localparam logic [ACT_W-1:0] ACT_ENERGIA   = 2'd1;
  localparam logic [ACT_W-1:0] ACT_HAMBRE    = 2'd2;
  localparam logic [ACT_W-1:0] ACT_DIVERSION = 2'd3;

  typedef enum logic {ST_IDLE, ST_OFFER} sched_state_e;

  // First set request strictly after ptr, wrapping; ptr itself is checked last.
  function automatic logic [ACT_W-1:0] rr_pick(input logic [NUM_ACT-1:0] req,
                                               input logic [ACT_W-1:0]   ptr);
    logic [ACT_W-1:0] idx;
    rr_pick = ptr;
    for (int i = NUM_ACT; i >= 1; i--) begin
      idx = ptr + ACT_W'(i);
      if (req[idx]) rr_pick = idx;
    end
  endfunction
endpackage

// File: rtl/tamagotchi_btn_scheduler_hold_timer.sv
// Long-press timer: counts whole ticks of a held level (saturating at 7) and
// emits a registered one-cycle fire when the count steps onto HOLD_THRESH.
module hold_timer #(
  parameter int TICK_CYCLES = 50_000_000,
  parameter int HOLD_THRESH = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       level_i,
  input  logic       clear_i,
  output logic [2:0] count_o,
  output logic       fire_o
);
  localparam int PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;

  logic [PW-1:0] presc_q, presc_d;
  logic [2:0]    count_q, count_d;
  logic          fire_q, fire_d;

  always_comb begin
    presc_d = '0;
    count_d = '0;
    fire_d  = 1'b0;
    if (level_i && !clear_i) begin
      if (presc_q == PW'(TICK_CYCLES - 1)) begin
        presc_d = '0;
        count_d = (count_q == 3'd7) ? 3'd7 : count_q + 3'd1;
        // Saturation means this transition happens at most once per press.
        fire_d  = (count_q == 3'(HOLD_THRESH - 1));
      end else begin
        presc_d = presc_q + PW'(1);
        count_d = count_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc_q <= '0;
      count_q <= '0;
      fire_q  <= 1'b0;
    end else begin
      presc_q <= presc_d;
      count_q <= count_d;
      fire_q  <= fire_d;
    end
  end

  assign count_o = count_q;
  assign fire_o  = fire_q;
endmodule

// File: rtl/tamagotchi_btn_scheduler.sv
// Button front-end: queues one request per care button, serialises them
// round-robin over valid/ready, and times long presses of reset/test.
module tamagotchi_btn_scheduler
  import tamagotchi_pkg::*;
#(
  parameter int TICK_CYCLES = 50_000_000,
  parameter int HOLD_THRESH = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             btn_salud,
  input  logic             btn_energia,
  input  logic             btn_hambre,
  input  logic             btn_diversion,
  input  logic             btn_reset,
  input  logic             btn_test,
  input  logic             act_ready,
  output logic             act_valid,
  output logic [ACT_W-1:0] act_code,
  output logic [3:0]       pending,
  output logic [2:0]       count_reset,
  output logic [2:0]       count_test,
  output logic             reset_req,
  output logic             test_mode
);
  logic [NUM_ACT-1:0] btn_lvl, prev_q, pend_q, pend_d, clr, rise;
  logic [ACT_W-1:0]   code_q, code_d, ptr_q, ptr_d;
  sched_state_e       state_q, state_d;
  logic               rst_fire, tst_fire, test_mode_q;

  assign btn_lvl = {btn_diversion, btn_hambre, btn_energia, btn_salud};
  assign rise    = btn_lvl & ~prev_q;

  hold_timer #(.TICK_CYCLES(TICK_CYCLES), .HOLD_THRESH(HOLD_THRESH)) u_rst_tmr (
    .clk(clk), .rst_n(rst_n), .level_i(btn_reset), .clear_i(1'b0),
    .count_o(count_reset), .fire_o(rst_fire));

  // Reset button has priority: the test timer is held cleared while it is down.
  hold_timer #(.TICK_CYCLES(TICK_CYCLES), .HOLD_THRESH(HOLD_THRESH)) u_tst_tmr (
    .clk(clk), .rst_n(rst_n), .level_i(btn_test), .clear_i(btn_reset),
    .count_o(count_test), .fire_o(tst_fire));

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    ptr_d   = ptr_q;
    clr     = '0;
    case (state_q)
      ST_IDLE: if (pend_q != '0) begin
        code_d  = rr_pick(pend_q, ptr_q);
        state_d = ST_OFFER;
      end
      ST_OFFER: if (act_ready) begin
        clr[code_q] = 1'b1;
        ptr_d       = code_q;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // A new edge on the bit being accepted keeps the request alive.
    pend_d = (pend_q & ~clr) | rise;
    if (rst_fire) begin
      pend_d  = '0;
      ptr_d   = ACT_DIVERSION;
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev_q      <= '0;
      pend_q      <= '0;
      code_q      <= '0;
      ptr_q       <= ACT_DIVERSION;
      state_q     <= ST_IDLE;
      test_mode_q <= 1'b0;
    end else begin
      prev_q      <= btn_lvl;
      pend_q      <= pend_d;
      code_q      <= code_d;
      ptr_q       <= ptr_d;
      state_q     <= state_d;
      test_mode_q <= test_mode_q ^ tst_fire;
    end
  end

  assign act_valid = (state_q == ST_OFFER) && !rst_fire;
  assign act_code  = code_q;
  assign pending   = pend_q;
  assign reset_req = rst_fire;
  assign test_mode = test_mode_q;
endmodule

// File: tb/tb_tamagotchi_btn_scheduler.sv
// Directed bench for the button scheduler with a 4-cycle tick and threshold 5.
module tb_tamagotchi_btn_scheduler;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       btn_salud, btn_energia, btn_hambre, btn_diversion, btn_reset, btn_test;
  logic       act_ready;
  logic       act_valid;
  logic [1:0] act_code;
  logic [3:0] pending;
  logic [2:0] count_reset, count_test;
  logic       reset_req, test_mode;
  int         total = 0;
  int         bad   = 0;

  tamagotchi_btn_scheduler #(.TICK_CYCLES(4), .HOLD_THRESH(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .btn_salud(btn_salud), .btn_energia(btn_energia), .btn_hambre(btn_hambre),
    .btn_diversion(btn_diversion), .btn_reset(btn_reset), .btn_test(btn_test),
    .act_ready(act_ready), .act_valid(act_valid), .act_code(act_code),
    .pending(pending), .count_reset(count_reset), .count_test(count_test),
    .reset_req(reset_req), .test_mode(test_mode));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_care(input logic [3:0] v);
    {btn_diversion, btn_hambre, btn_energia, btn_salud} = v;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; set_care(4'h0); btn_reset = 1'b0; btn_test = 1'b0; act_ready = 1'b0;
    tick(); tick();
    chk("rst_valid", 8'(act_valid), 8'h0);
    chk("rst_code", 8'(act_code), 8'h0);
    chk("rst_pending", 8'(pending), 8'h0);
    chk("rst_counts", 8'({count_reset, count_test}), 8'h0);
    chk("rst_flags", 8'({reset_req, test_mode}), 8'h0);
    rst_n = 1'b1;

    // 1: single energia pulse, valid two cycles after the edge
    act_ready = 1'b1; set_care(4'b0010);
    tick(); set_care(4'h0);
    chk("t1_pend", 8'(pending), 8'h2);
    chk("t1_valid0", 8'(act_valid), 8'h0);
    tick();
    chk("t1_valid", 8'(act_valid), 8'h1);
    chk("t1_code", 8'(act_code), 8'h1);
    tick();
    chk("t1_done_valid", 8'(act_valid), 8'h0);
    chk("t1_done_pend", 8'(pending), 8'h0);

    // 2: all four at once drain 0,1,2,3 with an idle cycle between offers
    do_reset();
    act_ready = 1'b1; set_care(4'hF);
    tick(); set_care(4'h0);
    chk("t2_pend", 8'(pending), 8'hF);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t2_valid", 8'(act_valid), 8'h1);
      chk("t2_code", 8'(act_code), 8'(i));
      tick();
      chk("t2_gap", 8'(act_valid), 8'h0);
    end
    chk("t2_empty", 8'(pending), 8'h0);

    // 3: stall, duplicate press collapses, set wins over accept-clear
    do_reset();
    act_ready = 1'b0; set_care(4'b0001);
    tick(); set_care(4'h0);
    tick();
    for (int i = 0; i < 10; i++) begin
      if (i == 3) set_care(4'b0001);
      if (i == 4) set_care(4'h0);
      chk("t3_hold_valid", 8'(act_valid), 8'h1);
      chk("t3_hold_code", 8'(act_code), 8'h0);
      tick();
    end
    chk("t3_one_req", 8'(pending), 8'h1);
    act_ready = 1'b1; set_care(4'b0001);
    tick(); set_care(4'h0);
    chk("t3_setwins_pend", 8'(pending), 8'h1);
    chk("t3_setwins_valid", 8'(act_valid), 8'h0);
    tick();
    chk("t3_reoffer", 8'({act_valid, act_code}), 8'h4);
    tick();
    chk("t3_drained", 8'(pending), 8'h0);

    // 4: long reset press with an offer outstanding
    do_reset();
    act_ready = 1'b0; set_care(4'b1100);
    tick(); set_care(4'h0);
    tick();
    chk("t4_offer_code", 8'(act_code), 8'h2);
    btn_reset = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      tick();
      chk("t4_count", 8'(count_reset), 8'((i / 4 > 7) ? 7 : i / 4));
      chk("t4_req", 8'(reset_req), 8'(i == 20));
      chk("t4_valid", 8'(act_valid), 8'(i < 20));
      chk("t4_pend", 8'(pending), (i <= 20) ? 8'hC : 8'h0);
    end
    btn_reset = 1'b0;
    tick();
    chk("t4_release", 8'(count_reset), 8'h0);
    chk("t4_release_req", 8'(reset_req), 8'h0);

    // 5: two test long presses toggle, then both held keeps test count at 0
    for (int p = 0; p < 2; p++) begin
      btn_test = 1'b1;
      for (int i = 1; i <= 20; i++) begin
        tick();
        if (i == 20) chk("t5_cnt5", 8'(count_test), 8'h5);
      end
      chk("t5_mode_before", 8'(test_mode), 8'(p));
      btn_test = 1'b0;
      tick();
      chk("t5_mode_after", 8'(test_mode), 8'(1 - p));
      chk("t5_cnt_clr", 8'(count_test), 8'h0);
    end
    btn_test = 1'b1; btn_reset = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      chk("t5_both_test", 8'(count_test), 8'h0);
    end
    chk("t5_both_rst", 8'(count_reset), 8'h2);
    btn_test = 1'b0; btn_reset = 1'b0;
    tick();
    chk("t5_mode_kept", 8'(test_mode), 8'h0);

    // 6: rst_n during an offer abandons it; salud wins first afterwards
    btn_test = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    btn_test = 1'b0;
    tick();
    chk("t6_mode_set", 8'(test_mode), 8'h1);
    act_ready = 1'b0; set_care(4'b0010);
    tick(); set_care(4'h0);
    tick();
    chk("t6_offer", 8'({act_valid, act_code}), 8'h5);
    rst_n = 1'b0;
    tick();
    chk("t6_valid", 8'(act_valid), 8'h0);
    chk("t6_code", 8'(act_code), 8'h0);
    chk("t6_pend", 8'(pending), 8'h0);
    chk("t6_mode", 8'(test_mode), 8'h0);
    rst_n = 1'b1; act_ready = 1'b1;
    tick();
    chk("t6_empty", 8'({act_valid, pending}), 8'h0);
    set_care(4'hF);
    tick(); set_care(4'h0);
    tick();
    chk("t6_first", 8'({act_valid, act_code}), 8'h4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
